// File: rtl/store_buffer.sv
// store_buffer: write buffer between the store unit and data memory.
// Accepts one store per cycle, aligns data to byte lanes, builds byte enables,
// and queues entries in a small FIFO that drains to memory over req/ack.
// A word-granular hazard flag tells the load path an overlapping store is pending.
module store_buffer #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       st_valid_i,
    input  logic [DATA_W-1:0]          st_addr_i,
    input  logic [DATA_W-1:0]          st_data_i,
    input  logic [2:0]                 st_funct3_i,
    output logic                       st_ready_o,
    output logic                       st_err_o,
    input  logic [DATA_W-1:0]          ld_addr_i,
    output logic                       ld_hazard_o,
    output logic                       mem_req_o,
    output logic [DATA_W-1:0]          mem_addr_o,
    output logic [DATA_W-1:0]          mem_wdata_o,
    output logic [3:0]                 mem_be_o,
    input  logic                       mem_ack_i,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       empty_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int AW = DATA_W - 2;

    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;

    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    // A store is legal when funct3 names a supported width and the address
    // is naturally aligned for that width.
    function automatic logic align_legal(input logic [2:0] f3, input logic [1:0] a);
        logic ok;
        ok = 1'b0;
        case (f3)
            F3_SB:   ok = 1'b1;
            F3_SH:   ok = (a[0] == 1'b0);
            F3_SW:   ok = (a == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Byte enables for the lanes touched by the store.
    function automatic logic [3:0] align_be(input logic [2:0] f3, input logic [1:0] a);
        logic [3:0] be;
        be = 4'b0000;
        case (f3)
            F3_SB:   be = 4'b0001 << a;
            F3_SH:   be = a[1] ? 4'b1100 : 4'b0011;
            F3_SW:   be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Replicate the significant part of tostore across all lanes so memory
    // can pick it up under any byte enable pattern.
    function automatic logic [DATA_W-1:0] align_data(input logic [2:0] f3,
                                                     input logic [DATA_W-1:0] d);
        logic [DATA_W-1:0] w;
        w = '0;
        case (f3)
            F3_SB:   w = {(DATA_W/8){d[7:0]}};
            F3_SH:   w = {(DATA_W/16){d[15:0]}};
            F3_SW:   w = d;
            default: w = '0;
        endcase
        return w;
    endfunction

    // FIFO storage and control state
    logic [AW-1:0]     addr_q  [DEPTH];
    logic [DATA_W-1:0] wdata_q [DEPTH];
    logic [3:0]        be_q    [DEPTH];
    logic [PW-1:0]     head_q, head_d;
    logic [PW-1:0]     tail_q, tail_d;
    logic [CW-1:0]     count_q, count_d;
    logic              st_err_q, st_err_d;

    logic              full;
    logic              legal;
    logic              push;
    logic              pop;
    logic [3:0]        new_be;
    logic [DATA_W-1:0] new_wdata;

    assign full      = (count_q == FULL_CNT);
    assign legal     = align_legal(st_funct3_i, st_addr_i[1:0]);
    assign new_be    = align_be(st_funct3_i, st_addr_i[1:0]);
    assign new_wdata = align_data(st_funct3_i, st_data_i);

    // ready depends on the registered count only, so an ack never opens a
    // slot in the same cycle and there is no ack-to-ready path
    assign push = st_valid_i && !full && legal;
    assign pop  = (count_q != '0) && mem_ack_i;

    // Next-state for pointers, occupancy and the reject pulse
    always_comb begin
        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q;
        st_err_d = st_valid_i && !legal;
        if (push) begin
            tail_d = tail_q + PW'(1);
        end
        if (pop) begin
            head_d = head_q + PW'(1);
        end
        count_d = count_q + CW'(push) - CW'(pop);
    end

    // Control registers; async clear drops mem_req without waiting for a clock
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            st_err_q <= 1'b0;
        end else begin
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            st_err_q <= st_err_d;
        end
    end

    // Entry storage: written at the tail on push, cleared on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i]  <= '0;
                wdata_q[i] <= '0;
                be_q[i]    <= '0;
            end
        end else if (push) begin
            addr_q[tail_q]  <= st_addr_i[DATA_W-1:2];
            wdata_q[tail_q] <= new_wdata;
            be_q[tail_q]    <= new_be;
        end
    end

    // Word-granular hazard over occupied entries; an entry is occupied when
    // its distance from head (mod DEPTH) is below count
    logic [PW-1:0] offs;
    logic          hazard;
    always_comb begin
        hazard = 1'b0;
        offs   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offs = PW'(i) - head_q;
            if (({1'b0, offs} < count_q) && (addr_q[i] == ld_addr_i[DATA_W-1:2])) begin
                hazard = 1'b1;
            end
        end
    end

    assign ld_hazard_o = hazard;
    assign st_ready_o  = !full;
    assign st_err_o    = st_err_q;
    assign mem_req_o   = (count_q != '0);
    assign mem_addr_o  = {addr_q[head_q], 2'b00};
    assign mem_wdata_o = wdata_q[head_q];
    assign mem_be_o    = be_q[head_q];
    assign count_o     = count_q;
    assign empty_o     = (count_q == '0);

endmodule

// File: tb/tb_store_buffer.sv
// Testbench for store_buffer: directed steps plus random traffic, each cycle
// compared against a queue-based reference model.
module tb_store_buffer;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;
    localparam int CW     = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              st_valid;
    logic [DATA_W-1:0] st_addr;
    logic [DATA_W-1:0] st_data;
    logic [2:0]        st_funct3;
    logic              st_ready;
    logic              st_err;
    logic [DATA_W-1:0] ld_addr;
    logic              ld_hazard;
    logic              mem_req;
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [3:0]        mem_be;
    logic              mem_ack;
    logic [CW-1:0]     count;
    logic              empty;

    store_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .st_valid_i (st_valid),
        .st_addr_i  (st_addr),
        .st_data_i  (st_data),
        .st_funct3_i(st_funct3),
        .st_ready_o (st_ready),
        .st_err_o   (st_err),
        .ld_addr_i  (ld_addr),
        .ld_hazard_o(ld_hazard),
        .mem_req_o  (mem_req),
        .mem_addr_o (mem_addr),
        .mem_wdata_o(mem_wdata),
        .mem_be_o   (mem_be),
        .mem_ack_i  (mem_ack),
        .count_o    (count),
        .empty_o    (empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } ent_t;

    ent_t q[$];
    bit   exp_err;
    int   n_chk;
    int   n_fail;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Store width in bytes from funct3; 0 for unsupported encodings
    function automatic int size_of(input logic [2:0] f3);
        if (f3 == 3'd0) return 1;
        if (f3 == 3'd1) return 2;
        if (f3 == 3'd2) return 4;
        return 0;
    endfunction

    function automatic bit m_legal(input logic [2:0] f3, input logic [31:0] a);
        int n;
        n = size_of(f3);
        return (n != 0) && ((a % n) == 0);
    endfunction

    function automatic ent_t m_entry(input logic [2:0] f3, input logic [31:0] a,
                                     input logic [31:0] d);
        ent_t e;
        int   n;
        n       = size_of(f3);
        e.addr  = a & 32'hFFFF_FFFC;
        e.be    = 4'(((1 << n) - 1) << (a % 4));
        if (n == 1)      e.wdata = {24'd0, d[7:0]} * 32'h0101_0101;
        else if (n == 2) e.wdata = {16'd0, d[15:0]} * 32'h0001_0001;
        else             e.wdata = d;
        return e;
    endfunction

    // Check all outputs against the model, then advance one clock.
    // Caller drives inputs just after a falling edge.
    task automatic tick();
        bit   h;
        bit   do_push;
        bit   do_pop;
        ent_t e;
        #1;
        chk("count", 32'(count), 32'(q.size()));
        chk("empty", 32'(empty), 32'(q.size() == 0));
        chk("st_ready", 32'(st_ready), 32'(q.size() < DEPTH));
        chk("mem_req", 32'(mem_req), 32'(q.size() != 0));
        chk("st_err", 32'(st_err), 32'(exp_err));
        if (q.size() != 0) begin
            chk("mem_addr", mem_addr, q[0].addr);
            chk("mem_wdata", mem_wdata, q[0].wdata);
            chk("mem_be", 32'(mem_be), 32'(q[0].be));
        end
        h = 1'b0;
        foreach (q[i]) if (q[i].addr[31:2] == ld_addr[31:2]) h = 1'b1;
        chk("ld_hazard", 32'(ld_hazard), 32'(h));
        do_pop  = (q.size() != 0) && mem_ack;
        do_push = st_valid && (q.size() < DEPTH) && m_legal(st_funct3, st_addr);
        e       = m_entry(st_funct3, st_addr, st_data);
        @(posedge clk);
        if (do_pop) void'(q.pop_front());
        if (do_push) q.push_back(e);
        exp_err = st_valid && !m_legal(st_funct3, st_addr);
        @(negedge clk);
    endtask

    task automatic offer(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        st_valid  = 1'b1;
        st_funct3 = f3;
        st_addr   = a;
        st_data   = d;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_chk     = 0;
        n_fail    = 0;
        exp_err   = 1'b0;
        rst_n     = 1'b0;
        st_valid  = 1'b0;
        st_addr   = '0;
        st_data   = '0;
        st_funct3 = '0;
        ld_addr   = 32'hFFFF_FFF0;
        mem_ack   = 1'b0;

        // Reset values
        repeat (2) @(negedge clk);
        #1;
        chk("rst_count", 32'(count), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_ready", 32'(st_ready), 1);
        chk("rst_mem_req", 32'(mem_req), 0);
        chk("rst_st_err", 32'(st_err), 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_mem_be", 32'(mem_be), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // SW 0x100, one-cycle push to memory, ack empties
        offer(3'b010, 32'h100, 32'hDEAD_BEEF);
        tick();
        st_valid = 1'b0;
        chk("sw_mem_req", 32'(mem_req), 1);
        chk("sw_mem_addr", mem_addr, 32'h100);
        chk("sw_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        chk("sw_mem_be", 32'(mem_be), 32'hF);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("sw_empty_after_ack", 32'(empty), 1);
        tick();

        // Lane alignment
        offer(3'b000, 32'h103, 32'h0000_00A5);
        tick();
        offer(3'b001, 32'h102, 32'h0000_1234);
        tick();
        st_valid = 1'b0;
        chk("sb_be", 32'(mem_be), 32'h8);
        chk("sb_wdata", mem_wdata, 32'hA5A5_A5A5);
        chk("sb_addr", mem_addr, 32'h100);
        mem_ack = 1'b1;
        tick();
        chk("sh_be", 32'(mem_be), 32'hC);
        chk("sh_wdata", mem_wdata, 32'h1234_1234);
        tick();
        mem_ack = 1'b0;
        tick();

        // Misaligned store rejected, single-cycle error pulse
        offer(3'b010, 32'h101, 32'h1111_2222);
        tick();
        st_valid = 1'b0;
        chk("mis_err", 32'(st_err), 1);
        chk("mis_count", 32'(count), 0);
        tick();
        chk("mis_err_clear", 32'(st_err), 0);
        tick();

        // Fill, hold a fifth store while full, then drain in order
        for (int i = 0; i < 4; i++) begin
            offer(3'b010, 32'h180 + 32'(i * 4), 32'hA000_0000 + 32'(i));
            tick();
        end
        chk("full_count", 32'(count), 4);
        chk("full_ready", 32'(st_ready), 0);
        offer(3'b010, 32'h1C0, 32'hB000_0005);
        repeat (3) tick();
        chk("full_held_count", 32'(count), 4);
        mem_ack = 1'b1;
        tick();
        tick();
        st_valid = 1'b0;
        repeat (6) tick();
        chk("drain_empty", 32'(empty), 1);
        mem_ack = 1'b0;

        // Wrap with simultaneous push and pop
        mem_ack = 1'b1;
        for (int i = 0; i < 10; i++) begin
            offer(3'b010, 32'h300 + 32'(i * 4), $urandom);
            tick();
            chk("wrap_count_le1", 32'(count <= 1), 1);
        end
        st_valid = 1'b0;
        tick();
        tick();
        mem_ack = 1'b0;

        // Random traffic, including illegal funct3 and misaligned addresses
        for (int i = 0; i < 400; i++) begin
            st_valid  = ($urandom_range(0, 3) != 0);
            st_funct3 = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7))
                                                    : 3'($urandom_range(0, 2));
            st_addr   = 32'h400 + 32'($urandom_range(0, 31));
            st_data   = $urandom;
            mem_ack   = ($urandom_range(0, 2) != 0);
            ld_addr   = 32'h400 + 32'($urandom_range(0, 35));
            tick();
        end
        st_valid = 1'b0;
        mem_ack  = 1'b1;
        repeat (6) tick();
        mem_ack = 1'b0;
        ld_addr = 32'hFFFF_FFF0;
        tick();

        // Hazard probe, then asynchronous reset during a pending request
        offer(3'b000, 32'h205, 32'h0000_0077);
        tick();
        st_valid = 1'b0;
        ld_addr  = 32'h204;
        #1;
        chk("haz_204", 32'(ld_hazard), 1);
        ld_addr = 32'h208;
        #1;
        chk("haz_208", 32'(ld_hazard), 0);
        chk("haz_mem_req", 32'(mem_req), 1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_mem_req", 32'(mem_req), 0);
        chk("async_rst_empty", 32'(empty), 1);
        chk("async_rst_ready", 32'(st_ready), 1);
        q.delete();
        exp_err = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        ld_addr = 32'h204;
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/store_buffer.md
# store_buffer

Write buffer between the store unit and data memory in the COREV core. Each cycle it accepts at most one store from the execute stage: the store unit's `tostore` value, the effective address and funct3. It aligns the data to its byte lanes, generates byte enables, and queues the result in a small FIFO. The FIFO drains to data memory over a req/ack handshake. A word-granular hazard flag lets the load path stall while an overlapping store is still pending.

## Interface
- `DATA_W`, 32, data and address width (matches `DataBusBits`)
- `DEPTH`, 4, FIFO entries; power of two, 2..16
- `clk` in 1, single clock; all state updates on the rising edge
- `rst_n` in 1, asynchronous, active-low reset
- `st_valid` in 1, store issued this cycle
- `st_addr` in DATA_W, byte effective address
- `st_data` in DATA_W, `tostore` from the store unit; only the low byte, halfword or word is significant
- `st_funct3` in 3, 000 SB, 001 SH, 010 SW
- `st_ready` out 1, buffer can accept a store this cycle
- `st_err` out 1, one-cycle pulse: last offered store was dropped (misaligned or illegal funct3)
- `ld_addr` in DATA_W, load probe address
- `ld_hazard` out 1, combinational: a pending entry targets the same word as `ld_addr`
- `mem_req` out 1, head entry presented to memory
- `mem_addr` out DATA_W, word-aligned address (bits [1:0] = 0)
- `mem_wdata` out DATA_W, lane-replicated write data
- `mem_be` out 4, byte enables
- `mem_ack` in 1, memory accepted the presented write
- `count` out log2(DEPTH)+1, occupied entries
- `empty` out 1, count == 0

## Operation
- **Push.** A push occurs on `st_valid && st_ready`.
  - `st_ready = !full`, from registered count only. A pop in the same cycle does not open a slot.
- **Alignment, with `a = st_addr[1:0]`:**
  - SB: `be = 4'b0001 << a`; `wdata = {4{st_data[7:0]}}`.
  - SH: requires `a[0]==0`. `be = a[1] ? 1100 : 0011`; `wdata = {2{st_data[15:0]}}`.
  - SW: requires `a==0`. `be = 1111`; `wdata = st_data`.
  - Misaligned SH/SW, or any other funct3: no push, no state change except `st_err`, which is 1 in the following cycle.
- **Entry contents.** Each entry holds `{addr[DATA_W-1:2], wdata, be}`.
- **FIFO structure.** Head and tail pointers are log2(DEPTH) bits and wrap modulo DEPTH. Count is kept separately.
- **Drain.**
  - `mem_req = !empty`. `mem_addr`, `mem_wdata` and `mem_be` come from the head entry, each as `mem_*` = head entry field.
  - These outputs stay stable while `mem_req && !mem_ack`.
  - When `mem_ack` is sampled high with `mem_req`, the head pops.
  - `mem_ack` while empty is ignored.
- **Simultaneous push and pop** (not full): count is unchanged and both pointers advance.
- **Ordering.** Entries drain strictly in push order. Stores to the same word are never merged.
- **Hazard.**
  - `ld_hazard = OR` over occupied entries of `(entry.addr == ld_addr[DATA_W-1:2])`.
  - The comparison ignores byte enables and excludes the store being pushed in the current cycle.
- **Reset.** Entries, pointers and count clear to 0. All outputs are 0 except `st_ready=1` and `empty=1`.
  - Asserting reset during a pending handshake discards every entry, and `mem_req` drops immediately (asynchronously).

## Timing
- **Push to memory:** a store pushed into an empty buffer in cycle N gives `mem_req=1` with its data in cycle N+1.
- **Drain throughput:** one entry per cycle when `mem_ack` is held high.
- **Back-to-back pops:** after an ack in cycle N, the next entry is presented in cycle N+1 if one exists. Otherwise `mem_req=0` in N+1.
- **`st_ready` and `st_err`:** both are registered; `st_err` lasts exactly one cycle per rejected store.
- **Combinational paths:** only `ld_hazard` depends combinationally on an input (`ld_addr`). No path exists from `mem_ack` to `st_ready`.

## Test plan
- **Reset values.** Stimulus: reset, then SW addr 0x100, data 0xDEADBEEF. Response: after reset release, `empty=1`, `mem_req=0`, `st_ready=1`. Next cycle: `mem_req=1`, `mem_addr=0x100`, `mem_wdata=0xDEADBEEF`, `mem_be=1111`. With `mem_ack=1`, `empty=1` the cycle after.
- **Lane alignment.** Stimulus: SB 0x103 data 0x000000A5, then SH 0x102 data 0x00001234. Response: first entry `be=1000`, `wdata=0xA5A5A5A5`, `addr=0x100`. Second entry `be=1100`, `wdata=0x12341234`.
- **Misaligned store rejected.** Stimulus: SW 0x101. Response: no push, `count=0`, `st_err=1` for exactly one cycle.
- **Full and in-order drain.** Stimulus: four SWs with `mem_ack=0`. Response: `count=4` and `st_ready=0`. A fifth store in the same window is not accepted and stays offered until a slot opens. Releasing ack drains all entries in order at one per cycle.
- **Wrap and simultaneous push/pop.** Stimulus: ten pushes with ack held high, with one push and one pop in the same cycles. Response: count stays ≤1, pointers wrap past DEPTH, and the write order at memory matches issue order.
- **Hazard and reset.** Stimulus: pending SB at 0x205, then probe `ld_addr` 0x204 and 0x208. Response: `ld_hazard` is 1 for 0x204 and 0 for 0x208. Asserting `rst_n=0` while `mem_req=1` drops `mem_req` without waiting for a clock.
